// File: rtl/handle_init_draw_n.sv
// Initial-deal engine for one player's board: deals INIT_HAND cards from the local deck
// into hand slots via inter-board draw messages. The INIT_DRAW_RETRY_EN macro adds a resend-on-timeout timer.
`default_nettype none

`ifndef P1_INIT_DRAW
`define P1_INIT_DRAW 4'd2
`endif
`ifndef DRAW_CARD
`define DRAW_CARD 4'd1
`endif
`ifndef STATE_CHANGE
`define STATE_CHANGE 4'd2
`endif

module handle_init_draw_n #(
   parameter int         PLAYER     = 0,
   // Per-player init-draw state codes are consecutive, starting at P1's.
   parameter logic [3:0] INIT_STATE = 4'(`P1_INIT_DRAW + PLAYER),
   parameter int         INIT_HAND  = 14,
   parameter int         ROW_LEN    = 18,
   parameter int         HAND_Y0    = 6,
   parameter int         TIMEOUT    = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       interboard_rst,
   input  logic [3:0] cur_game_state,
   input  logic       inter_ready,
   input  logic [5:0] deck_card,
   input  logic       deck_valid,
   input  logic       deck_empty,
   output logic       deck_req,
   output logic       init_draw_done,
   output logic       init_draw_err,
   output logic       init_draw_ctrl_en,
   output logic       init_draw_ctrl_move_dir,
   output logic [4:0] init_draw_ctrl_block_x,
   output logic [2:0] init_draw_ctrl_block_y,
   output logic [3:0] init_draw_ctrl_msg_type,
   output logic [5:0] init_draw_ctrl_card,
   output logic [2:0] init_draw_ctrl_sel_len
);

   localparam int CW = $clog2(INIT_HAND + 1);

   if (INIT_HAND < 1 || INIT_HAND > 63 || ROW_LEN < 1 || ROW_LEN > 32 || TIMEOUT < 1) begin : g_bad_params
      $error("handle_init_draw_n: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, REQ, FETCH, SEND, WAIT, FIN_SEND, FIN_WAIT, DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          deck_req_q, deck_req_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          en_q, en_d;
   logic [4:0]    x_q, x_d, slot_x;
   logic [2:0]    y_q, y_d, slot_y;
   logic [3:0]    msg_q, msg_d;
   logic [5:0]    card_q, card_d;
   logic [2:0]    sel_q, sel_d;
   logic          active;
   logic          timeout_hit;

   assign active  = (cur_game_state == INIT_STATE);
   assign cnt_inc = cnt_q + CW'(1);
   assign slot_x  = 5'(int'(cnt_q) % ROW_LEN);
   assign slot_y  = 3'(HAND_Y0 + int'(cnt_q) / ROW_LEN);

`ifdef INIT_DRAW_RETRY_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmr_q, tmr_d;

   assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));

   // Timer runs only while parked in a wait state; every strobe restarts it.
   always_comb begin
      tmr_d = '0;
      if ((state_q == WAIT || state_q == FIN_WAIT) && state_d == state_q)
         tmr_d = tmr_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                tmr_q <= '0;
      else if (interboard_rst) tmr_q <= '0;
      else                     tmr_q <= tmr_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (!active && state_q != IDLE && state_q != DONE) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (active) state_d = REQ;
            end
            REQ: begin
               if (deck_empty) begin
                  err_d   = 1'b1;
                  state_d = FIN_SEND;
               end else begin
                  state_d = FETCH;
               end
            end
            FETCH:    if (deck_valid) state_d = SEND;
            SEND:     state_d = WAIT;
            WAIT: begin
               if (inter_ready) begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == CW'(INIT_HAND)) ? FIN_SEND : REQ;
               end else if (timeout_hit) begin
                  state_d = SEND;
               end
            end
            FIN_SEND: state_d = FIN_WAIT;
            FIN_WAIT: begin
               if (inter_ready)      state_d = DONE;
               else if (timeout_hit) state_d = FIN_SEND;
            end
            DONE:     if (!active) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Outputs are registered against the next state so each pulse lines up with its state.
   // Payload loads only on a fresh message; a resend reuses the held fields unchanged.
   always_comb begin
      deck_req_d = (state_q == REQ) && (state_d == FETCH);
      done_d     = (state_q == FIN_WAIT) && (state_d == DONE);
      en_d       = (state_d == SEND) || (state_d == FIN_SEND);
      x_d        = x_q;
      y_d        = y_q;
      msg_d      = msg_q;
      card_d     = card_q;
      sel_d      = sel_q;
      if (state_q == FETCH && state_d == SEND) begin
         msg_d  = `DRAW_CARD;
         card_d = deck_card;
         x_d    = slot_x;
         y_d    = slot_y;
         sel_d  = 3'd1;
      end else if (state_d == FIN_SEND && state_q != FIN_WAIT) begin
         msg_d  = `STATE_CHANGE;
         card_d = '0;
         x_d    = '0;
         y_d    = '0;
         sel_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         deck_req_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         en_q       <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         msg_q      <= '0;
         card_q     <= '0;
         sel_q      <= '0;
      end else if (interboard_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         deck_req_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         en_q       <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         msg_q      <= '0;
         card_q     <= '0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         deck_req_q <= deck_req_d;
         done_q     <= done_d;
         err_q      <= err_d;
         en_q       <= en_d;
         x_q        <= x_d;
         y_q        <= y_d;
         msg_q      <= msg_d;
         card_q     <= card_d;
         sel_q      <= sel_d;
      end
   end

   assign deck_req                = deck_req_q;
   assign init_draw_done          = done_q;
   assign init_draw_err           = err_q;
   assign init_draw_ctrl_en       = en_q;
   assign init_draw_ctrl_move_dir = 1'b0;
   assign init_draw_ctrl_block_x  = x_q;
   assign init_draw_ctrl_block_y  = y_q;
   assign init_draw_ctrl_msg_type = msg_q;
   assign init_draw_ctrl_card     = card_q;
   assign init_draw_ctrl_sel_len  = sel_q;

endmodule

`default_nettype wire

// File: doc/handle_init_draw_n.md
Name: handle_init_draw_n

Overview:
Parametrised initial-deal engine for one player's board. While the global game state equals this player's init-draw state, it pulls INIT_HAND cards from the local deck and sends one draw message per card over the inter-board link, waiting for the link handshake on each message. Each card goes into the next hand slot in row-major order. The block then sends a state-change message and pulses done. It sits in GameControl beside the other per-state handlers, and its ctrl outputs are muxed into the inter-board transmitter.

Parameters:
PLAYER, 0, player index; selects the matching init-draw state.
INIT_STATE, `P1_INIT_DRAW, 4-bit game-state code that activates this block.
INIT_HAND, 14, cards to deal (1..63).
ROW_LEN, 18, hand slots per row (1..32).
HAND_Y0, 6, block_y of the first hand row.
TIMEOUT, 1023, cycles to wait for inter_ready before resend (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
interboard_rst  in  1  synchronous clear, highest priority after rst
cur_game_state  in  4  global game state
inter_ready  in  1  transmitter acknowledge for the last ctrl_en message
deck_card  in  6  card at deck head
deck_valid  in  1  deck_card valid (response to deck_req)
deck_empty  in  1  deck exhausted
deck_req  out  1  one-cycle pop request to the deck
init_draw_done  out  1  one-cycle completion pulse
init_draw_err  out  1  sticky; set when the deck empties mid-deal
init_draw_ctrl_en  out  1  one-cycle message strobe
init_draw_ctrl_move_dir  out  1  always 0 (deck to hand)
init_draw_ctrl_block_x  out  5  hand slot column
init_draw_ctrl_block_y  out  3  hand slot row
init_draw_ctrl_msg_type  out  4  `DRAW_CARD or `STATE_CHANGE
init_draw_ctrl_card  out  6  card dealt
init_draw_ctrl_sel_len  out  3  always 1 for draw, 0 for state change

Behaviour:
- All outputs are registered.
- Reset values (rst low, async) and interboard_rst (sync): state IDLE; cnt=0; every output 0.
- active = (cur_game_state == INIT_STATE).
- FSM:
  - IDLE: when active, go to REQ. When not active, stay in IDLE and force cnt=0.
  - REQ: if deck_empty, set err and go to FIN_SEND. Otherwise pulse deck_req for one cycle and go to FETCH.
  - FETCH: wait for deck_valid, then latch deck_card and go to SEND.
  - SEND: drive ctrl_en=1 for exactly one cycle.
    - msg_type=`DRAW_CARD, card=latched card.
    - block_x = cnt % ROW_LEN; block_y = HAND_Y0 + cnt / ROW_LEN, truncated to 3 bits.
    - Go to WAIT.
  - WAIT: inter_ready is sampled from the cycle after SEND onward; a high in the SEND cycle itself is ignored.
    - On inter_ready: cnt+1. If cnt+1 == INIT_HAND go to FIN_SEND, else go to REQ.
  - FIN_SEND: one-cycle ctrl_en with msg_type=`STATE_CHANGE, card=0, block_x=0, block_y=0, sel_len=0. Go to FIN_WAIT.
  - FIN_WAIT: on inter_ready, pulse init_draw_done for one cycle and go to DONE.
  - DONE: hold until active drops, then go to IDLE. No re-deal while still in the same state.
- Throughput: minimum 5 cycles per card (REQ, FETCH with deck_valid in the next cycle, SEND, WAIT with immediate ready, back to REQ).
- Field hold: ctrl payload fields keep their value between strobes; only ctrl_en pulses.
- Abort: if active drops in any state other than IDLE or DONE, go to IDLE next cycle and clear cnt. No done pulse. A partial deal is the game controller's responsibility.
- Sticky error: err stays set until rst or interboard_rst.
- Simultaneous events:
  - interboard_rst beats everything.
  - An active drop beats inter_ready in the same cycle.
- cnt width: clog2(INIT_HAND+1).

Optional Feature:
INIT_DRAW_RETRY_EN
- Defined: a WAIT/FIN_WAIT timer counts cycles. After TIMEOUT cycles with no inter_ready, the FSM returns to SEND/FIN_SEND and re-strobes the identical message. The timer clears on each strobe. There is no retry limit.
- Undefined: no timer; WAIT/FIN_WAIT block indefinitely.

Test Plan:
1. INIT_HAND=14, ROW_LEN=18, deck supplies cards 1..14, inter_ready two cycles after each strobe -> exactly 14 DRAW strobes with block_x 0..13, block_y 6, cards 1..14; then one STATE_CHANGE strobe; one done pulse; err=0.
2. INIT_HAND=20, ROW_LEN=18 -> card 19 at (x=0,y=7), card 20 at (x=1,y=7); done after the 21st strobe.
3. deck_empty asserted after 5 cards -> err=1; STATE_CHANGE sent; done pulse; cnt=5.
4. cur_game_state changes during the WAIT of card 3 -> IDLE next cycle, no further strobes, no done; re-entering the state restarts at block_x=0.
5. rst pulled low mid-deal, then interboard_rst for one cycle mid-deal -> all outputs 0 immediately (async) or on the next edge (sync); inter_ready arriving in the same cycle as interboard_rst is ignored.
6. With INIT_DRAW_RETRY_EN and TIMEOUT=8, inter_ready withheld -> an identical strobe repeats every 9 cycles; after ready the deal advances normally. Without the macro -> a single strobe, then the block stalls.
